fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 82 ++++++++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state type, widths and NOP word
// for the instruction fetch unit and its prefetch buffer.
package fetch_pkg;

  localparam int DATA_WIDTH_DEF = 20;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 2;

  localparam int NOP_MAX_W = 64;
  localparam logic [NOP_MAX_W-1:0] NOP_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DISCARD
  } fetch_state_e;

  function automatic int cnt_width(int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two prefetch buffer.
// Clear wins over a same-cycle push or pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 28,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    wr_d;
  logic [PW-1:0]    rd_q;
  logic [PW-1:0]    rd_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  assign do_push = push_i && !clear_i;
  assign do_pop  = pop_i && !clear_i && !empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        wr_d = wr_q + PW'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload needs no reset: it is masked by the count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher
// feeding a prefetch buffer, with flush/redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ADDRESS_WIDTH = ADDR_WIDTH_DEF,
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     PCWrite,
  input  logic                     IF_ID_Write,
  input  logic                     Flush,
  input  logic [ADDRESS_WIDTH-1:0] branch_target,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ack,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic                     if_valid,
  output logic [DATA_WIDTH-1:0]    instruction,
  output logic [ADDRESS_WIDTH-1:0] pc_result
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int EW = DATA_WIDTH + AW;
  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_e  state_q;
  fetch_state_e  state_d;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;

  logic          busy;
  logic          can_issue;
  logic [CW-1:0] slots_used;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;

  assign busy       = (state_q != ST_IDLE);
  assign slots_used = fifo_count + CW'(busy);
  assign can_issue  = PCWrite && !Flush
                   && (slots_used < DEPTH_C);
  assign pop        = !fifo_empty && IF_ID_Write
                   && !Flush;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    push    = 1'b0;
    if (Flush) begin
      pc_d = branch_target;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (can_issue) begin
          state_d = ST_WAIT;
          addr_d  = pc_q;
          pc_d    = pc_q + AW'(1);
        end
      end
      ST_WAIT: begin
        if (imem_ack) begin
          state_d = ST_IDLE;
          push    = !Flush && !fifo_full;
        end else if (Flush) begin
          state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (imem_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (Flush),
    .data_i  ({imem_rdata, addr_q}),
    .data_o  (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign imem_req    = busy;
  assign imem_addr   = busy ? addr_q : '0;
  assign if_valid    = !fifo_empty;
  assign instruction = if_valid ? head[EW-1:AW]
                     : NOP_WORD[DATA_WIDTH-1:0];
  assign pc_result   = if_valid ? head[AW-1:0] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random fetch traffic
// against a stream-level model of the fetcher.
module tb_fetch_unit;

  localparam int DW    = 20;
  localparam int AW    = 8;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          PCWrite;
  logic          IF_ID_Write;
  logic          Flush;
  logic [AW-1:0] branch_target;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          if_valid;
  logic [DW-1:0] instruction;
  logic [AW-1:0] pc_result;

  fetch_unit #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PCWrite       (PCWrite),
    .IF_ID_Write   (IF_ID_Write),
    .Flush         (Flush),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .instruction   (instruction),
    .pc_result     (pc_result)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] memw [256];
  int            checks = 0;
  int            errors = 0;
  int            lat_cfg;
  int            lat_cur;
  int            wait_cnt;
  int            cnt;
  logic [AW-1:0] exp_issue;
  logic [AW-1:0] exp_pop;
  logic [AW-1:0] held;
  logic [AW-1:0] last_issue;
  logic [AW-1:0] tgt;
  bit            discard;
  bit            req_seen;
  bit            exp_req;
  bit            have_last;
  bit            wrap_seen;
  bit            found;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cnt       = 0;
    exp_issue = '0;
    exp_pop   = '0;
    discard   = 0;
    req_seen  = 0;
    exp_req   = 0;
    wait_cnt  = 0;
    have_last = 0;
    imem_ack  = 0;
  endtask

  // Called at a falling edge with inputs already set.
  task automatic step();
    bit ack;
    bit pop;
    bit push_ok;
    if (imem_req && !req_seen)
      lat_cur = (lat_cfg < 0) ? $urandom_range(3, 0)
                              : lat_cfg;
    ack        = imem_req && req_seen ? (wait_cnt >= lat_cur)
               : (imem_req && lat_cur == 0);
    imem_ack   = ack;
    imem_rdata = ack ? memw[imem_addr] : DW'($urandom);
    chk("req", imem_req, exp_req);
    if (imem_req && !req_seen) begin
      chk("issue_addr", imem_addr, exp_issue);
      if (have_last && last_issue == 8'hFF
          && imem_addr == 8'h00)
        wrap_seen = 1;
      last_issue = imem_addr;
      have_last  = 1;
      held       = imem_addr;
      exp_issue  = exp_issue + 1'b1;
      req_seen   = 1;
    end else if (imem_req) begin
      chk("addr_hold", imem_addr, held);
    end
    chk("valid", if_valid, cnt > 0);
    if (if_valid) begin
      chk("head_pc", pc_result, exp_pop);
      chk("head_insn", instruction, memw[exp_pop]);
    end else begin
      chk("nop_insn", instruction, 0);
      chk("nop_pc", pc_result, 0);
    end
    pop     = (cnt > 0) && IF_ID_Write && !Flush;
    push_ok = ack && !discard && !Flush;
    exp_req = exp_req ? !ack
            : (PCWrite && !Flush && cnt < DEPTH);
    if (pop) exp_pop = exp_pop + 1'b1;
    cnt = cnt - int'(pop) + int'(push_ok);
    if (Flush) begin
      cnt       = 0;
      exp_pop   = branch_target;
      exp_issue = branch_target;
    end
    if (Flush && imem_req && !ack) discard = 1;
    else if (ack) discard = 0;
    if (ack) begin
      req_seen = 0;
      wait_cnt = 0;
    end else if (imem_req) begin
      wait_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_insn", instruction, 0);
    chk("rst_pc", pc_result, 0);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b1;
  endtask

  initial begin
    rst           = 1'b0;
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    Flush         = 1'b0;
    branch_target = '0;
    imem_ack      = 1'b0;
    imem_rdata    = '0;
    lat_cfg       = 1;
    lat_cur       = 1;
    wrap_seen     = 0;
    for (int i = 0; i < 256; i++)
      memw[i] = DW'($urandom);
    model_reset();
    @(negedge clk);
    do_reset();

    // Streaming with one-cycle memory.
    repeat (30) step();

    // Stalled consumer: buffer fills to two.
    do_reset();
    IF_ID_Write = 1'b0;
    repeat (10) step();
    chk("b_req_idle", imem_req, 0);
    chk("b_valid", if_valid, 1);
    chk("b_head", pc_result, 8'h00);
    IF_ID_Write = 1'b1;
    repeat (12) step();

    // Flush while waiting on address 5.
    do_reset();
    lat_cfg = 3;
    found   = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (imem_req && !req_seen && imem_addr == 8'h05)
        found = 1;
      else
        step();
    end
    chk("c_found", found, 1);
    Flush         = 1'b1;
    branch_target = 8'h40;
    step();
    Flush = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (if_valid) found = 1;
      else step();
    end
    chk("c_got_valid", found, 1);
    chk("c_first_pc", pc_result, 8'h40);
    repeat (10) step();

    // Flush together with ack and pop.
    do_reset();
    lat_cfg     = 1;
    IF_ID_Write = 1'b0;
    found       = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (if_valid && imem_req && req_seen
          && wait_cnt >= lat_cur)
        found = 1;
      else
        step();
    end
    chk("d_found", found, 1);
    tgt           = AW'($urandom);
    IF_ID_Write   = 1'b1;
    Flush         = 1'b1;
    branch_target = tgt;
    step();
    Flush = 1'b0;
    chk("d_empty", if_valid, 0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_req) found = 1;
      else step();
    end
    chk("d_got_req", found, 1);
    chk("d_req_addr", imem_addr, tgt);
    repeat (8) step();

    // Address wrap 0xFF -> 0x00.
    lat_cfg       = 0;
    wrap_seen     = 0;
    Flush         = 1'b1;
    branch_target = 8'hFE;
    step();
    Flush = 1'b0;
    repeat (15) step();
    chk("e_wrap", wrap_seen, 1);

    // Reset while a request is outstanding.
    do_reset();
    lat_cfg     = 2;
    IF_ID_Write = 1'b0;
    found       = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (if_valid && imem_req) found = 1;
      else step();
    end
    chk("f_found", found, 1);
    do_reset();
    IF_ID_Write = 1'b1;
    found       = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_req) found = 1;
      else step();
    end
    chk("f_got_req", found, 1);
    chk("f_first_addr", imem_addr, 8'h00);

    // Random traffic.
    do_reset();
    lat_cfg = -1;
    for (int i = 0; i < 600; i++) begin
      PCWrite       = ($urandom_range(9, 0) != 0);
      IF_ID_Write   = ($urandom_range(2, 0) != 0);
      Flush         = ($urandom_range(29, 0) == 0);
      branch_target = AW'($urandom);
      step();
    end
    Flush = 1'b0;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
